leaf_spine_uplink: RTL
======================

# leaf_spine_uplink

Leaf-side endpoint of one spine link: packetizes local transmit requests into header and payload flits toward a spine router leaf port. It also depacketizes flits arriving from that port into a local receive stream. It sits in the leaf/GPU node and is the far end of the spine's per-leaf valid-only link. Transmit flow control uses credits. Receive admission is whole-packet, so packets are never truncated.

## Interface
- GROUP_ID, 4'b0001, group of this leaf; inserted as source group, matched as destination group
- LEAF_ID, 4'd1, leaf index within the group; matched as destination leaf
- DWIDTH, 16, flit width; must be ≥16; bits above 15 are zero in headers
- FIFO_DEPTH, 8, spine-side input FIFO depth (initial credits) and local RX FIFO depth
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- tx_req_valid / tx_req_ready  in/out  1  packet request handshake
- tx_dest_group  in  4  destination group
- tx_dest_leaf  in  4  destination leaf
- tx_len  in  4  payload flit count, 1–15
- tx_data  in  DWIDTH  payload flit
- tx_data_valid / tx_data_ready  in/out  1  payload handshake
- up_data  out  DWIDTH  flit to spine leaf port
- up_valid  out  1  flit strobe to spine
- up_credit  in  1  one pulse per flit drained by the spine
- dn_data  in  DWIDTH  flit from spine leaf port
- dn_valid  in  1  flit strobe from spine; no backpressure
- rx_data  out  DWIDTH  delivered payload flit
- rx_valid / rx_ready  out/in  1  delivery handshake
- rx_sop, rx_eop  out  1  first and last payload flit markers
- rx_src_group  out  4  source group of the current flit
- rx_overflow  out  1  sticky; a packet was dropped because the FIFO lacked space
- tx_pkt_cnt, rx_drop_cnt  out  16  statistics (see Configuration)

## Operation
- Header flit layout: [15:12] dest group, [11:8] dest leaf, [7:4] source group, [3:0] len.
- Credit counter: range 0..FIFO_DEPTH, reset value FIFO_DEPTH.
  - Decrements on each up_valid.
  - Increments on up_credit.
  - Simultaneous decrement and increment leaves it unchanged.
  - up_credit while already at FIFO_DEPTH is ignored (saturates).
- TX FSM states: T_IDLE, T_HDR, T_PAY.
  - T_IDLE: tx_req_ready=1. An accepted request with tx_len=0 is consumed and emits nothing. Otherwise the request is latched and the FSM moves to T_HDR.
  - T_HDR: the header is sent when credits>0, then the FSM moves to T_PAY with remaining=len.
  - T_PAY: tx_data_ready = credits>0. Each handshake sends one flit and decrements remaining. When remaining reaches 0, the FSM returns to T_IDLE and tx_pkt_cnt increments.
- RX FSM states: R_HDR, R_PAY, R_DROP.
  - R_HDR, dn_valid with a header flit: accept when dest group = GROUP_ID, dest leaf = LEAF_ID, and FIFO free ≥ len. On accept, go to R_PAY.
  - R_HDR, address mismatch: go to R_DROP and increment rx_drop_cnt.
  - R_HDR, insufficient space: go to R_DROP, increment rx_drop_cnt and set rx_overflow.
  - len=0 headers are ignored.
- RX FIFO entries hold {src_group, sop, eop, data}.
- R_PAY: every dn_valid enqueues one flit. The first flit carries sop and the len-th flit carries eop, then the FSM returns to R_HDR.
- R_DROP: counts off len flits, discarding them, then returns to R_HDR.
- Counters wrap at 2^16.

## Timing
- up_data and up_valid are registered.
  - The header appears the cycle after request acceptance, given a credit.
  - A payload handshake in cycle M appears on up_valid in M+1.
  - Back-to-back flits are sustained while credits last.
- A dn flit in cycle N is visible on rx_valid at N+1 at the earliest (no bypass).
- rx_data, rx_sop, rx_eop and rx_src_group are held stable while rx_valid=1 and rx_ready=0.
- Reset values:
  - All outputs 0, including tx_req_ready and tx_data_ready.
  - tx_req_ready rises on the first clk edge after deassertion.
  - Credits = FIFO_DEPTH, FIFO empty, FSMs in T_IDLE / R_HDR.
- Reset mid-packet aborts both FSMs. The spine must be reset in the same window.
- A simultaneous FIFO push and pop at full is not possible: admission guarantees space.

## Configuration
- LEAF_SPINE_UPLINK_STATS_EN defined: tx_pkt_cnt and rx_drop_cnt are live counters, reset to 0.
- Not defined: both are tied to 0 and no counter flops exist. rx_overflow is unaffected.

## Structure
- Package leaf_uplink_pkg holds:
  - header field offsets and widths
  - TX/RX state enums
  - MAX_LEN=15
- Sub-module uplink_rx_fifo: synchronous FIFO, depth FIFO_DEPTH, width DWIDTH+6, with a free-count output used for admission.

## Test plan
- Request group=2, leaf=3, len=3, payload A1,A2,A3 → up_data 0x2313, then A1, A2, A3 on consecutive cycles; tx_pkt_cnt=1.
- No up_credit returned, two len=7 requests → 8 flits sent, then stall with tx_data_ready=0. One up_credit pulse → exactly one more flit.
- dn header 0x1145 (to group 1, leaf 1, from group 4, len 5), then 5 flits → rx delivers 5 flits; sop on the first, eop on the fifth, rx_src_group=4.
- dn header 0x1242 (leaf 2 mismatch), then 2 flits, then a valid len=1 packet → first packet discarded, rx_drop_cnt=1; second delivered.
- rx_ready=0 with 6 flits buffered, then a len=3 header arrives → dropped, rx_overflow=1, FIFO contents intact.
- Reset asserted in the middle of a len=10 TX packet → up_valid=0 immediately; credits=8 after release; a fresh request sends its header first.

Source files
------------

// File: rtl/leaf_spine_uplink_pkg.sv
`default_nettype none
// ============================================================================
// Module : leaf_uplink_pkg
// Brief  : Header field layout, FSM state types and limits for the uplink.
// Rev    : 1.0
// ============================================================================
package leaf_uplink_pkg;

  localparam int HDR_W         = 16;
  localparam int FIELD_W       = 4;
  localparam int HDR_DGRP_LSB  = 12;
  localparam int HDR_DLEAF_LSB = 8;
  localparam int HDR_SGRP_LSB  = 4;
  localparam int HDR_LEN_LSB   = 0;
  localparam int MAX_LEN       = 15;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_HDR  = 2'd1,
    T_PAY  = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    R_HDR  = 2'd0,
    R_PAY  = 2'd1,
    R_DROP = 2'd2
  } rx_state_e;

  function automatic logic [HDR_W-1:0] pack_hdr(
    input logic [FIELD_W-1:0] dgrp,
    input logic [FIELD_W-1:0] dleaf,
    input logic [FIELD_W-1:0] sgrp,
    input logic [FIELD_W-1:0] len
  );
    return {dgrp, dleaf, sgrp, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_spine_uplink_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uplink_rx_fifo
// Brief  : Synchronous receive FIFO with a free-entry count for admission.
// Rev    : 1.0
// ============================================================================
module uplink_rx_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             valid_o,
  output logic [CW-1:0]    free_o
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             w_pop;

  assign w_pop = pop_i && valid_o;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push_i, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o    = (count_q != '0);
  assign free_o     = CW'(DEPTH) - count_q;
  // Gate the read port so an empty FIFO presents all-zero outputs.
  assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/leaf_spine_uplink.sv
`default_nettype none
// ============================================================================
// Module : leaf_spine_uplink
// Brief  : Leaf endpoint of a spine link; credit-based packetizer and
//          whole-packet-admission depacketizer. LEAF_SPINE_UPLINK_STATS_EN
//          enables the tx_pkt_cnt / rx_drop_cnt statistics counters.
// Rev    : 1.0
// ============================================================================
module leaf_spine_uplink
  import leaf_uplink_pkg::*;
#(
  parameter logic [3:0] GROUP_ID   = 4'b0001,
  parameter logic [3:0] LEAF_ID    = 4'd1,
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tx_req_valid_i,
  output logic              tx_req_ready_o,
  input  logic [3:0]        tx_dest_group_i,
  input  logic [3:0]        tx_dest_leaf_i,
  input  logic [3:0]        tx_len_i,
  input  logic [DWIDTH-1:0] tx_data_i,
  input  logic              tx_data_valid_i,
  output logic              tx_data_ready_o,
  output logic [DWIDTH-1:0] up_data_o,
  output logic              up_valid_o,
  input  logic              up_credit_i,
  input  logic [DWIDTH-1:0] dn_data_i,
  input  logic              dn_valid_i,
  output logic [DWIDTH-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_sop_o,
  output logic              rx_eop_o,
  output logic [3:0]        rx_src_group_o,
  output logic              rx_overflow_o,
  output logic [15:0]       tx_pkt_cnt_o,
  output logic [15:0]       rx_drop_cnt_o
);

  localparam int            CW       = $clog2(FIFO_DEPTH + 1);
  localparam int            EW       = DWIDTH + 6;
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------- TX path
  tx_state_e         tx_state_q, tx_state_d;
  logic [3:0]        dgrp_q, dgrp_d, dleaf_q, dleaf_d, rem_q, rem_d;
  logic [CW-1:0]     cred_q, cred_d;
  logic [DWIDTH-1:0] up_data_q, up_data_d, w_hdr;
  logic              up_valid_q, up_valid_d;
  logic              live_q, w_has_cred, w_pkt_done;

  assign w_has_cred = (cred_q != '0);

  // In T_IDLE the header is built from the request itself so it can leave
  // on the acceptance edge; T_HDR only covers the no-credit case.
  always_comb begin
    w_hdr = '0;
    if (tx_state_q == T_IDLE)
      w_hdr[HDR_W-1:0] = pack_hdr(tx_dest_group_i, tx_dest_leaf_i, GROUP_ID, tx_len_i);
    else
      w_hdr[HDR_W-1:0] = pack_hdr(dgrp_q, dleaf_q, GROUP_ID, rem_q);
  end

  always_comb begin
    tx_state_d      = tx_state_q;
    dgrp_d          = dgrp_q;
    dleaf_d         = dleaf_q;
    rem_d           = rem_q;
    up_valid_d      = 1'b0;
    up_data_d       = up_data_q;
    tx_req_ready_o  = 1'b0;
    tx_data_ready_o = 1'b0;
    w_pkt_done      = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        tx_req_ready_o = live_q;
        if (live_q && tx_req_valid_i && (tx_len_i != 4'd0)) begin
          dgrp_d  = tx_dest_group_i;
          dleaf_d = tx_dest_leaf_i;
          rem_d   = tx_len_i;
          if (w_has_cred) begin
            up_valid_d = 1'b1;
            up_data_d  = w_hdr;
            tx_state_d = T_PAY;
          end else begin
            tx_state_d = T_HDR;
          end
        end
      end
      T_HDR: begin
        if (w_has_cred) begin
          up_valid_d = 1'b1;
          up_data_d  = w_hdr;
          tx_state_d = T_PAY;
        end
      end
      T_PAY: begin
        tx_data_ready_o = w_has_cred;
        if (tx_data_valid_i && w_has_cred) begin
          up_valid_d = 1'b1;
          up_data_d  = tx_data_i;
          rem_d      = rem_q - 1'b1;
          if (rem_q == 4'd1) begin
            tx_state_d = T_IDLE;
            w_pkt_done = 1'b1;
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase

    cred_d = cred_q;
    if (up_valid_d && !up_credit_i)
      cred_d = cred_q - 1'b1;
    else if (!up_valid_d && up_credit_i && (cred_q != CRED_MAX))
      cred_d = cred_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= T_IDLE;
      dgrp_q     <= '0;
      dleaf_q    <= '0;
      rem_q      <= '0;
      cred_q     <= CRED_MAX;
      up_data_q  <= '0;
      up_valid_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      dgrp_q     <= dgrp_d;
      dleaf_q    <= dleaf_d;
      rem_q      <= rem_d;
      cred_q     <= cred_d;
      up_data_q  <= up_data_d;
      up_valid_q <= up_valid_d;
      live_q     <= 1'b1;
    end
  end

  assign up_data_o  = up_data_q;
  assign up_valid_o = up_valid_q;

  // ---------------------------------------------------------------- RX path
  rx_state_e     rx_state_q, rx_state_d;
  logic [3:0]    rrem_q, rrem_d, src_q, src_d, w_dn_len;
  logic          first_q, first_d, ovf_q, ovf_d;
  logic          w_push, w_drop, w_match;
  logic [EW-1:0] w_entry, w_rd_entry;
  logic [CW-1:0] w_free;

  assign w_dn_len = dn_data_i[HDR_LEN_LSB +: FIELD_W];
  assign w_match  = (dn_data_i[HDR_DGRP_LSB +: FIELD_W] == GROUP_ID) &&
                    (dn_data_i[HDR_DLEAF_LSB +: FIELD_W] == LEAF_ID);
  assign w_entry  = {src_q, first_q, (rrem_q == 4'd1), dn_data_i};

  always_comb begin
    rx_state_d = rx_state_q;
    rrem_d     = rrem_q;
    src_d      = src_q;
    first_d    = first_q;
    ovf_d      = ovf_q;
    w_push     = 1'b0;
    w_drop     = 1'b0;
    case (rx_state_q)
      R_HDR: begin
        if (dn_valid_i && (w_dn_len != 4'd0)) begin
          rrem_d  = w_dn_len;
          src_d   = dn_data_i[HDR_SGRP_LSB +: FIELD_W];
          first_d = 1'b1;
          if (!w_match) begin
            rx_state_d = R_DROP;
            w_drop     = 1'b1;
          end else if (32'(w_free) < 32'(w_dn_len)) begin
            rx_state_d = R_DROP;
            w_drop     = 1'b1;
            ovf_d      = 1'b1;
          end else begin
            rx_state_d = R_PAY;
          end
        end
      end
      R_PAY, R_DROP: begin
        if (dn_valid_i) begin
          w_push  = (rx_state_q == R_PAY);
          first_d = 1'b0;
          rrem_d  = rrem_q - 1'b1;
          if (rrem_q == 4'd1) rx_state_d = R_HDR;
        end
      end
      default: rx_state_d = R_HDR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= R_HDR;
      rrem_q     <= '0;
      src_q      <= '0;
      first_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rrem_q     <= rrem_d;
      src_q      <= src_d;
      first_q    <= first_d;
      ovf_q      <= ovf_d;
    end
  end

  uplink_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_rx_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_push),
    .push_data_i (w_entry),
    .pop_i       (rx_ready_i),
    .pop_data_o  (w_rd_entry),
    .valid_o     (rx_valid_o),
    .free_o      (w_free)
  );

  assign {rx_src_group_o, rx_sop_o, rx_eop_o, rx_data_o} = w_rd_entry;
  assign rx_overflow_o = ovf_q;

  // ------------------------------------------------------------- statistics
`ifdef LEAF_SPINE_UPLINK_STATS_EN
  logic [15:0] tx_pkt_cnt_q, rx_drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_pkt_cnt_q  <= '0;
      rx_drop_cnt_q <= '0;
    end else begin
      if (w_pkt_done) tx_pkt_cnt_q  <= tx_pkt_cnt_q + 1'b1;
      if (w_drop)     rx_drop_cnt_q <= rx_drop_cnt_q + 1'b1;
    end
  end

  assign tx_pkt_cnt_o  = tx_pkt_cnt_q;
  assign rx_drop_cnt_o = rx_drop_cnt_q;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_pkt_done ^ w_drop;
  assign tx_pkt_cnt_o   = '0;
  assign rx_drop_cnt_o  = '0;
`endif

endmodule
`default_nettype wire
